// File: rtl/bram_bank_power_sequencer.sv
// One-bank-at-a-time wake/sleep sequencer for the BRAM bank array, with access-violation flagging.
// Optional statistics counters are built when POWER_SEQ_STATS_EN is defined.
module bram_bank_power_sequencer #(
   parameter int NUM_BANKS    = 19,
   parameter int WAKE_CYCLES  = 8,
   parameter int SLEEP_CYCLES = 4,
   localparam int IDX_W       = $clog2(NUM_BANKS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_BANKS-1:0] bank_power_en,
   input  logic [NUM_BANKS-1:0] bank_access,
   output logic [NUM_BANKS-1:0] bram_sleep,
   output logic [NUM_BANKS-1:0] bank_ready,
   output logic                 seq_busy,
   output logic                 power_settled,
   output logic                 access_violation,
   output logic [IDX_W-1:0]     violation_bank,
   output logic [15:0]          wake_count,
   output logic [31:0]          active_bank_cycles
);

   localparam int MAX_CYC = (WAKE_CYCLES > SLEEP_CYCLES) ? WAKE_CYCLES : SLEEP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {IDLE, WAKE, DRAIN} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [IDX_W-1:0]     sel, sel_next;
   logic [NUM_BANKS-1:0] sleep_next, ready_next;
   logic [NUM_BANKS-1:0] pend_up, pend_dn, viol;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_BANKS-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--)
         if (v[i]) lowest_idx = IDX_W'(i);
   endfunction

   assign pend_up = bank_power_en & ~bank_ready;
   assign pend_dn = ~bank_power_en & bank_ready;
   assign viol    = bank_access & ~bank_ready;

   // NOTE: every comb output gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      sel_next   = sel;
      sleep_next = bram_sleep;
      ready_next = bank_ready;
      unique case (state)
         IDLE: begin
            if (|pend_up) begin
               sel_next             = lowest_idx(pend_up);
               sleep_next[sel_next] = 1'b0;
               cnt_next             = CNT_W'(WAKE_CYCLES - 1);
               state_next           = WAKE;
            end else if (|pend_dn) begin
               sel_next             = lowest_idx(pend_dn);
               ready_next[sel_next] = 1'b0;
               cnt_next             = CNT_W'(SLEEP_CYCLES - 1);
               state_next           = DRAIN;
            end
         end
         WAKE: begin
            if (cnt == '0) begin
               ready_next[sel] = 1'b1;
               state_next      = IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         DRAIN: begin
            if (cnt == '0) begin
               sleep_next[sel] = 1'b1;
               state_next      = IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         sel              <= '0;
         bram_sleep       <= '1;
         bank_ready       <= '0;
         seq_busy         <= 1'b0;
         power_settled    <= 1'b0;
         access_violation <= 1'b0;
         violation_bank   <= '0;
      end else begin
         state            <= state_next;
         cnt              <= cnt_next;
         sel              <= sel_next;
         bram_sleep       <= sleep_next;
         bank_ready       <= ready_next;
         seq_busy         <= (state_next != IDLE);
         power_settled    <= (state == IDLE) && (bank_ready == bank_power_en);
         access_violation <= |viol;
         if (|viol) violation_bank <= lowest_idx(viol);
      end
   end

`ifdef POWER_SEQ_STATS_EN
   logic        wake_done;
   logic [32:0] active_sum;

   assign wake_done  = (state == WAKE) && (cnt == '0);
   assign active_sum = {1'b0, active_bank_cycles} + 33'($countones(bank_ready));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wake_count         <= '0;
         active_bank_cycles <= '0;
      end else begin
         if (wake_done && (wake_count != 16'hFFFF)) wake_count <= wake_count + 16'd1;
         active_bank_cycles <= active_sum[32] ? 32'hFFFF_FFFF : active_sum[31:0];
      end
   end
`else
   assign wake_count         = '0;
   assign active_bank_cycles = '0;
`endif

endmodule

// File: tb/tb_bram_bank_power_sequencer.sv
// Directed bench for bram_bank_power_sequencer: wake order, drain timing, priority,
// no-abort behaviour, access violations and mid-wake reset. Outputs sampled 1 ns after posedge.
module tb_bram_bank_power_sequencer;

   localparam int NB = 19;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] bank_power_en;
   logic [NB-1:0] bank_access;
   logic [NB-1:0] bram_sleep;
   logic [NB-1:0] bank_ready;
   logic          seq_busy;
   logic          power_settled;
   logic          access_violation;
   logic [4:0]    violation_bank;
   logic [15:0]   wake_count;
   logic [31:0]   active_bank_cycles;

   int n_cmp = 0;
   int n_err = 0;

   bram_bank_power_sequencer dut (
      .clk                (clk),
      .rst                (rst),
      .bank_power_en      (bank_power_en),
      .bank_access        (bank_access),
      .bram_sleep         (bram_sleep),
      .bank_ready         (bank_ready),
      .seq_busy           (seq_busy),
      .power_settled      (power_settled),
      .access_violation   (access_violation),
      .violation_bank     (violation_bank),
      .wake_count         (wake_count),
      .active_bank_cycles (active_bank_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bank_power_en = '0;
      bank_access   = '0;
      tick(3);
      check("rst_sleep", 32'(bram_sleep), 32'h7FFFF);
      check("rst_ready", 32'(bank_ready), 32'h0);
      check("rst_busy", 32'(seq_busy), 32'h0);
      check("rst_settled", 32'(power_settled), 32'h0);
      check("rst_viol", 32'(access_violation), 32'h0);
      check("rst_vbank", 32'(violation_bank), 32'h0);
      check("rst_wcount", 32'(wake_count), 32'h0);

      // Banks 0-3 wake in order; E1 is bank 0's selection edge.
      rst           = 1'b0;
      bank_power_en = 19'h0000F;
      tick(1);                                             // E1
      check("w0_sleep", 32'(bram_sleep), 32'h7FFFE);
      check("w0_busy", 32'(seq_busy), 32'h1);
      check("w0_ready_early", 32'(bank_ready), 32'h0);
      tick(7);                                             // E8
      check("w0_ready_e8", 32'(bank_ready), 32'h0);
      tick(1);                                             // E9
      check("w0_ready", 32'(bank_ready), 32'h1);
      tick(8);                                             // E17
      check("w1_ready_e17", 32'(bank_ready), 32'h1);
      tick(1);                                             // E18
      check("w1_ready", 32'(bank_ready), 32'h3);
      tick(9);                                             // E27
      check("w2_ready", 32'(bank_ready), 32'h7);
      tick(9);                                             // E36
      check("w3_ready", 32'(bank_ready), 32'hF);
      check("w3_settled_early", 32'(power_settled), 32'h0);
      tick(1);                                             // E37
      check("w3_settled", 32'(power_settled), 32'h1);
      check("w3_busy", 32'(seq_busy), 32'h0);
      check("w3_sleep", 32'(bram_sleep), 32'h7FFF0);
`ifdef POWER_SEQ_STATS_EN
      check("wcount_4", 32'(wake_count), 32'h4);
`else
      check("wcount_tied", 32'(wake_count), 32'h0);
      check("abc_tied", active_bank_cycles, 32'h0);
`endif

      // Drop bank 2: ready falls at once, sleep rises four edges later.
      bank_power_en = 19'h0000B;
      tick(1);                                             // E38
      check("d2_ready", 32'(bank_ready), 32'hB);
      check("d2_busy", 32'(seq_busy), 32'h1);
      check("d2_sleep_held", 32'(bram_sleep), 32'h7FFF0);
      tick(3);                                             // E41
      check("d2_busy_e41", 32'(seq_busy), 32'h1);
      check("d2_sleep_e41", 32'(bram_sleep), 32'h7FFF0);
      tick(1);                                             // E42
      check("d2_sleep", 32'(bram_sleep), 32'h7FFF4);
      check("d2_busy_done", 32'(seq_busy), 32'h0);
      tick(1);                                             // E43
      check("d2_settled", 32'(power_settled), 32'h1);

      // Wake 5 and 6 before draining 1.
      bank_power_en = 19'h00069;
      tick(1);                                             // E44
      check("p5_sleep", 32'(bram_sleep), 32'h7FFD4);
      check("p5_ready_b1", 32'(bank_ready), 32'hB);
      tick(8);                                             // E52
      check("p5_ready", 32'(bank_ready), 32'h2B);
      tick(1);                                             // E53
      check("p6_sleep", 32'(bram_sleep), 32'h7FF94);
      tick(8);                                             // E61
      check("p6_ready", 32'(bank_ready), 32'h6B);
      tick(1);                                             // E62
      check("p1_ready", 32'(bank_ready), 32'h69);
      check("p1_busy", 32'(seq_busy), 32'h1);
      tick(4);                                             // E66
      check("p1_sleep", 32'(bram_sleep), 32'h7FF96);
      tick(1);                                             // E67
      check("p_settled", 32'(power_settled), 32'h1);

      // Bank 7 de-requested mid-wake: the wake completes, then it drains.
      bank_power_en = 19'h000E9;
      tick(1);                                             // E68
      check("m7_sleep", 32'(bram_sleep), 32'h7FF16);
      tick(2);                                             // E70
      bank_power_en = 19'h00069;
      tick(2);                                             // E72
      check("m7_busy_mid", 32'(seq_busy), 32'h1);
      check("m7_ready_mid", 32'(bank_ready), 32'h69);
      tick(4);                                             // E76
      check("m7_ready", 32'(bank_ready), 32'hE9);
      check("m7_sleep_awake", 32'(bram_sleep), 32'h7FF16);
      tick(1);                                             // E77
      check("m7_drain_ready", 32'(bank_ready), 32'h69);
      check("m7_drain_busy", 32'(seq_busy), 32'h1);
      tick(4);                                             // E81
      check("m7_drain_sleep", 32'(bram_sleep), 32'h7FF96);
      check("m7_idle", 32'(seq_busy), 32'h0);

      // Access to sleeping banks 8 and 9 reports the lowest index.
      bank_access = 19'h00300;
      tick(1);                                             // E82
      bank_access = '0;
      check("v89_flag", 32'(access_violation), 32'h1);
      check("v89_bank", 32'(violation_bank), 32'h8);
      tick(1);                                             // E83
      check("v89_pulse_end", 32'(access_violation), 32'h0);
      check("v89_bank_hold", 32'(violation_bank), 32'h8);
      bank_access = 19'h00001;
      tick(1);                                             // E84
      bank_access = '0;
      check("vok_flag", 32'(access_violation), 32'h0);

      // Access during bank 4's settle window, then reset mid-wake.
      bank_power_en = 19'h00079;
      tick(2);                                             // E86
      check("r4_sleep", 32'(bram_sleep), 32'h7FF86);
      bank_access = 19'h00010;
      tick(1);                                             // E87
      bank_access = '0;
      check("v4_flag", 32'(access_violation), 32'h1);
      check("v4_bank", 32'(violation_bank), 32'h4);
      rst = 1'b1;
      #1;
      check("r_sleep", 32'(bram_sleep), 32'h7FFFF);
      check("r_ready", 32'(bank_ready), 32'h0);
      check("r_busy", 32'(seq_busy), 32'h0);
      check("r_vbank", 32'(violation_bank), 32'h0);
      check("r_wcount", 32'(wake_count), 32'h0);
      tick(2);
      rst           = 1'b0;
      bank_power_en = '0;
      tick(1);
      check("post_settled", 32'(power_settled), 32'h1);
      check("post_sleep", 32'(bram_sleep), 32'h7FFFF);
      check("post_busy", 32'(seq_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bram_bank_power_sequencer.md
Name: bram_bank_power_sequencer

Overview:
- Consumes the per-bank power-request vector produced by the power manager and applies it to the physical BRAM sleep controls.
- Wakes or sleeps one bank at a time, which limits inrush current and leaves no gap in access safety.
- Reports per-bank readiness back to the datapath.
- Flags any access to a bank that is not ready.
- Sits between the power manager and the BRAM bank array.

Parameters:
- NUM_BANKS, 19, number of BRAM banks; matches the request vector width.
- WAKE_CYCLES, 8, settle cycles (≥1) from sleep release until the bank is usable.
- SLEEP_CYCLES, 4, drain cycles (≥1) from ready removal until sleep is asserted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bank_power_en  in  NUM_BANKS  requested power state per bank (1 = on)
- bank_access  in  NUM_BANKS  datapath access strobe per bank
- bram_sleep  out  NUM_BANKS  sleep control to each BRAM bank (1 = asleep)
- bank_ready  out  NUM_BANKS  bank is powered and settled
- seq_busy  out  1  a wake or sleep transition is in progress
- power_settled  out  1  bank_ready == bank_power_en and sequencer idle
- access_violation  out  1  one-cycle pulse: access to a bank that was not ready
- violation_bank  out  $clog2(NUM_BANKS)  index of the offending bank
- wake_count  out  16  stats; see Optional Feature
- active_bank_cycles  out  32  stats; see Optional Feature

Behaviour:
- Reset (async assert, sync release) drives:
  - bram_sleep = all 1; bank_ready = 0; seq_busy = 0; power_settled = 0; access_violation = 0; violation_bank = 0.
  - FSM = IDLE; counter = 0; stats = 0.
  - Reset mid-transition abandons the transition; every bank returns to asleep.
- All outputs are registered.
- FSM states: IDLE, WAKE, DRAIN.
- IDLE, evaluated each cycle:
  - pend_up = bank_power_en & ~bank_ready; pend_dn = ~bank_power_en & bank_ready.
  - If pend_up != 0: pick lowest index i. On that edge, clear bram_sleep[i], load counter = WAKE_CYCLES-1, go to WAKE.
  - Else if pend_dn != 0: pick lowest index i. On that edge, clear bank_ready[i], load counter = SLEEP_CYCLES-1, go to DRAIN.
  - Wake always has priority over sleep, to keep compute-path latency low.
- WAKE:
  - Decrement counter each cycle.
  - On the edge where counter == 0: set bank_ready[i], return to IDLE.
- DRAIN:
  - Decrement counter each cycle.
  - On the edge where counter == 0: set bram_sleep[i], return to IDLE.
- Timing, taking edge N as the one where the bank is selected in IDLE:
  - Wake: bram_sleep[i] falls after edge N; bank_ready[i] rises after edge N+WAKE_CYCLES.
  - Sleep: bank_ready[i] falls after edge N; bram_sleep[i] rises after edge N+SLEEP_CYCLES.
  - Each transition costs WAKE_CYCLES+1 or SLEEP_CYCLES+1 cycles including the IDLE evaluation cycle.
- Request changes while in WAKE or DRAIN are ignored until the return to IDLE. A transition is never aborted.
  - Example: a bank de-requested mid-wake completes its wake, becomes ready, then is drained on a later IDLE pass.
- Invariants: bank_ready[i] implies !bram_sleep[i]. At most one bank is in transition at any time.
- seq_busy = (state != IDLE), registered.
- power_settled = 1 only when state is IDLE and bank_ready == bank_power_en. It is evaluated on registered values, so it has one cycle of latency.
- Access violation:
  - Each cycle, v = bank_access & ~bank_ready.
  - If v != 0: access_violation = 1 on the next cycle, and violation_bank = lowest set index of v.
  - Otherwise access_violation = 0 and violation_bank holds its last value.
  - Simultaneous violations on several banks report only the lowest index.
- Access to a bank during its WAKE settle window (bank_ready still 0) is a violation.

Optional Feature:
- Macro: POWER_SEQ_STATS_EN.
- Defined:
  - wake_count increments on each completed wake and saturates at 16'hFFFF.
  - active_bank_cycles adds popcount(bank_ready) every cycle and saturates at 32'hFFFF_FFFF.
  - Both clear on rst.
- Undefined:
  - Both ports remain and are tied to 0.
  - No counter logic is synthesized.

Test Plan:
- Reset, then hold bank_power_en = 0x0000F (banks 0-3) → banks wake in order 0,1,2,3.
  - bank_ready[0] rises 8 cycles after its selection edge.
  - Each further bank follows 9 cycles later.
  - power_settled = 1 one cycle after bank 3 is ready.
- All 4 ready, then drop bit 2 → bank_ready[2] falls on the next edge; bram_sleep[2] rises 4 cycles later; seq_busy is high exactly during that window.
- Request banks 5 and 6 on while bank 1 is de-requested in the same cycle → bank 5 wakes, then bank 6 wakes, then bank 1 drains (wake has priority).
- Mid-wake of bank 7, drop its request → the wake completes (bank_ready[7] = 1), the sequencer returns to IDLE, then bank 7 drains. No aborted transition.
- Pulse bank_access = 0x00300 while banks 8 and 9 are asleep → access_violation = 1 for one cycle and violation_bank = 8. A pulse on a ready bank gives no violation.
- Assert rst during the WAKE of bank 4 → bram_sleep returns to all 1 and bank_ready = 0 immediately. With POWER_SEQ_STATS_EN defined, wake_count resets to 0 and counts 4 after the banks 0-3 sequence.
